xps2_keyq: RTL and testbench

- Front end of the calculator's keyboard path: synchronises the raw PS/2 clock and data lines and deserialises 11-bit frames.
- Strips the break (F0) and extended (E0) prefixes, translates calculator-relevant make codes into 4-bit key codes, and queues them in a small FIFO.
- The controller reads the FIFO through the top-level address decoder as two memory-mapped words: data (read pops) and status.

---
 rtl/xps2_keyq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_xps2_keyq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xps2_keyq.sv
// PS/2 keyboard front end for the calculator. It synchronises the raw PS/2 lines,
// deserialises 11-bit frames and strips the E0/F0 prefixes. Calculator keys are
// translated to 4-bit codes and queued in a FIFO. The controller reads the FIFO
// through a two-word bus window: addr 0 is key data (a read pops), addr 1 is status.
// Optional feature macro: PS2_PARITY_CHK_EN enables odd-parity checking and a
// saturating parity-error counter in status[23:16].
module xps2_keyq #(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic        sel,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        key_avail
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StShift, StParity, StStop} rx_state_e;

  // Synchronisers: bit 0 is the newest sample, bit 1 the older one.
  logic [1:0]            r_sclk, r_sdat;
  rx_state_e             r_state, w_state_next;
  logic [2:0]            r_bit_cnt, w_bit_cnt_next;
  logic [7:0]            r_shift, w_shift_next;
  logic                  r_par, w_par_next;
  logic [TmoW-1:0]       r_tmo, w_tmo_next;
  logic                  r_ext, r_brk;
  logic [3:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [CntW-1:0]       r_count;
  logic                  r_ovf;
  logic                  r_key_avail;

  logic       w_fall, w_dat, w_par_ok, w_byte_valid, w_par_err;
  logic       w_is_prefix, w_key_hit;
  logic [3:0] w_key;
  logic       w_empty, w_full, w_push_req, w_push, w_pop, w_ovf_set, w_ovf_clr;
  logic [31:0] w_status;

  assign w_fall = r_sclk[1] & ~r_sclk[0];
  assign w_dat  = r_sdat[1];

`ifdef PS2_PARITY_CHK_EN
  assign w_par_ok = ^{r_shift, r_par};
  logic [7:0] r_perr;
  logic       w_perr_clr;
  logic       w_unused;
  assign w_perr_clr = sel & we & addr & data_in[3];
  assign w_unused   = ^{data_in[31:4], data_in[1:0]};
`else
  assign w_par_ok = 1'b1;
  logic w_unused;
  assign w_unused = ^{data_in[31:3], data_in[1:0], r_par};
`endif

  // Two-flop synchronisers; idle lines are high so reset to 1 avoids a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk <= 2'b11;
      r_sdat <= 2'b11;
    end else begin
      r_sclk <= {r_sclk[0], PS2_CLK};
      r_sdat <= {r_sdat[0], PS2_DATA};
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_tmo     <= w_tmo_next;
    end
  end

  // Receiver next state: frame sequencing, mid-frame timeout and byte strobe.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_tmo_next     = '0;
    w_byte_valid   = 1'b0;
    w_par_err      = 1'b0;
    if (r_state != StIdle && !w_fall) begin
      w_tmo_next = r_tmo + 1'b1;
    end
    unique case (r_state)
      StIdle: begin
        if (w_fall && !w_dat) begin
          w_state_next   = StShift;
          w_bit_cnt_next = '0;
        end
      end
      StShift: begin
        if (w_fall) begin
          w_shift_next   = {w_dat, r_shift[7:1]};
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = StParity;
        end
      end
      StParity: begin
        if (w_fall) begin
          w_par_next   = w_dat;
          w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_fall) begin
          w_state_next = StIdle;
          w_byte_valid = w_dat & w_par_ok;
          w_par_err    = ~w_par_ok;
        end
      end
      default: w_state_next = StIdle;
    endcase
    // No falling edge for TIMEOUT_CYC cycles: abandon the partial frame.
    if (r_state != StIdle && !w_fall && r_tmo == TmoW'(TIMEOUT_CYC - 1)) begin
      w_state_next = StIdle;
      w_tmo_next   = '0;
    end
  end

  // Scan-set-2 to calculator key translation; only 4A and 5A are valid after E0.
  always_comb begin
    w_key_hit   = 1'b1;
    w_key       = 4'h0;
    w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);
    if (r_ext) begin
      case (r_shift)
        8'h4A:   w_key = 4'hD;
        8'h5A:   w_key = 4'hE;
        default: w_key_hit = 1'b0;
      endcase
    end else begin
      case (r_shift)
        8'h45, 8'h70: w_key = 4'h0;
        8'h16, 8'h69: w_key = 4'h1;
        8'h1E, 8'h72: w_key = 4'h2;
        8'h26, 8'h7A: w_key = 4'h3;
        8'h25, 8'h6B: w_key = 4'h4;
        8'h2E, 8'h73: w_key = 4'h5;
        8'h36, 8'h74: w_key = 4'h6;
        8'h3D, 8'h6C: w_key = 4'h7;
        8'h3E, 8'h75: w_key = 4'h8;
        8'h46, 8'h7D: w_key = 4'h9;
        8'h79:        w_key = 4'hA;
        8'h7B, 8'h4E: w_key = 4'hB;
        8'h7C:        w_key = 4'hC;
        8'h5A:        w_key = 4'hE;
        8'h66:        w_key = 4'hF;
        default:      w_key_hit = 1'b0;
      endcase
    end
  end

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntW'(Depth));
  assign w_pop      = sel & ~we & ~addr & ~w_empty;
  assign w_push_req = w_byte_valid & ~w_is_prefix & ~r_brk & w_key_hit;
  // When full, a push only lands if a pop frees the head slot in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = sel & we & addr & data_in[2];

  // Prefix tracking: E0/F0 arm flags, any other byte consumes and clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_valid) begin
      if (r_shift == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_shift == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_key;
  end

  // FIFO pointers, occupancy, sticky overflow and the lagging key_avail flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_key_avail <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      r_key_avail <= ~w_empty;
    end
  end

`ifdef PS2_PARITY_CHK_EN
  // Saturating parity-error counter; a software clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr <= '0;
    end else if (w_perr_clr) begin
      r_perr <= '0;
    end else if (w_par_err && r_perr != 8'hFF) begin
      r_perr <= r_perr + 1'b1;
    end
  end
`endif

  assign key_avail = r_key_avail;

  // Status word and bus read mux; sel low forces zero.
  always_comb begin
    w_status                  = '0;
    w_status[0]               = ~w_empty;
    w_status[1]               = w_full;
    w_status[2]               = r_ovf;
    w_status[8 +: CntW]       = r_count;
`ifdef PS2_PARITY_CHK_EN
    w_status[23:16]           = r_perr;
`endif
    data_out = '0;
    if (sel) begin
      if (addr) begin
        data_out = w_status;
      end else if (!w_empty) begin
        data_out = {28'd0, r_mem[r_rptr]};
      end
    end
  end

endmodule

// File: tb/tb_xps2_keyq.sv
// Directed self-checking bench for xps2_keyq: PS/2 frames are bit-banged with a
// slow PS/2 clock and results are read back through the bus window.
module tb_xps2_keyq;

  localparam int unsigned Tmo = 500;

  logic        clk, rst, PS2_CLK, PS2_DATA, sel, we, addr;
  logic [31:0] data_in, data_out;
  logic        key_avail;
  int          n_cmp = 0;
  int          n_err = 0;

  xps2_keyq #(.DEPTH_LOG2(3), .TIMEOUT_CYC(Tmo)) dut (
    .clk       (clk),
    .rst       (rst),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .sel       (sel),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .key_avail (key_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_bit(input logic b);
    PS2_DATA = b;
    repeat (4) @(posedge clk);
    #1 PS2_CLK = 1'b0;
    repeat (4) @(posedge clk);
    #1 PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(stop);
    PS2_DATA = 1'b1;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] v);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 v = data_out;
    @(posedge clk);
    #1 sel = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1 sel = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #1 v = data_out;
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_data_out: got %h want %h", v, 32'h0); end
    n_cmp++;
    if (key_avail !== 1'b0) begin
      n_err++; $display("FAIL reset_key_avail: got %b want 0", key_avail);
    end
    sel = 1'b1; addr = 1'b1; #1 v = data_out; sel = 1'b0; addr = 1'b0;
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    send_frame(8'h16, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h16, 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h101) begin n_err++; $display("FAIL basic_status: got %h want %h", v, 32'h101); end
    n_cmp++;
    if (key_avail !== 1'b1) begin n_err++; $display("FAIL basic_avail: got %b want 1", key_avail); end
    bus_read(1'b0, v);
    n_cmp++;
    if (v !== 32'h1) begin n_err++; $display("FAIL basic_data: got %h want %h", v, 32'h1); end
    // key_avail lags the pop by one cycle.
    n_cmp++;
    if (key_avail !== 1'b1) begin
      n_err++; $display("FAIL basic_avail_lag: got %b want 1", key_avail);
    end
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL basic_status_after: got %h want %h", v, 32'h0); end
    n_cmp++;
    if (key_avail !== 1'b0) begin
      n_err++; $display("FAIL basic_avail_fall: got %b want 0", key_avail);
    end
  endtask

  task automatic test_extended;
    logic [31:0] v;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h4A, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h4A, 1'b0, 1'b1);
    send_frame(8'h4A, 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h101) begin n_err++; $display("FAIL ext_status: got %h want %h", v, 32'h101); end
    bus_read(1'b0, v);
    n_cmp++;
    if (v !== 32'hD) begin n_err++; $display("FAIL ext_data: got %h want %h", v, 32'hD); end
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL ext_status_after: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_keymap;
    logic [7:0]  codes [10] = '{8'h70, 8'h7D, 8'h79, 8'h4E, 8'h7C, 8'hE0, 8'h5A, 8'h66, 8'h3D,
                                8'h29};
    logic [31:0] exp [8] = '{32'h0, 32'h9, 32'hA, 32'hB, 32'hC, 32'hE, 32'hF, 32'h7};
    logic [31:0] v;
    for (int i = 0; i < 10; i++) send_frame(codes[i], 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h803) begin n_err++; $display("FAIL map_status: got %h want %h", v, 32'h803); end
    for (int i = 0; i < 8; i++) begin
      bus_read(1'b0, v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++; $display("FAIL map_data[%0d]: got %h want %h", i, v, exp[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    for (int i = 0; i < 9; i++) send_frame(8'h45, 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h807) begin n_err++; $display("FAIL ovf_status: got %h want %h", v, 32'h807); end
    bus_write(1'b1, 32'h4);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h803) begin n_err++; $display("FAIL ovf_clear: got %h want %h", v, 32'h803); end
    for (int i = 0; i < 8; i++) begin
      bus_read(1'b0, v);
      n_cmp++;
      if (v !== 32'h0) begin n_err++; $display("FAIL ovf_data[%0d]: got %h want %h", i, v, 32'h0); end
      if (i == 3) begin
        bus_read(1'b1, v);
        n_cmp++;
        if (v !== 32'h401) begin n_err++; $display("FAIL ovf_half: got %h want %h", v, 32'h401); end
      end
    end
    bus_read(1'b0, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL ovf_ninth: got %h want %h", v, 32'h0); end
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL ovf_empty: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_timeout;
    logic [31:0] v;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (Tmo + 1) @(posedge clk);
    #1 send_frame(8'h1E, 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h101) begin n_err++; $display("FAIL tmo_status: got %h want %h", v, 32'h101); end
    bus_read(1'b0, v);
    n_cmp++;
    if (v !== 32'h2) begin n_err++; $display("FAIL tmo_data: got %h want %h", v, 32'h2); end
  endtask

  task automatic test_bad_frames;
    logic [31:0] v;
    send_frame(8'h16, 1'b0, 1'b0);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL badstop_status: got %h want %h", v, 32'h0); end
    send_frame(8'h5A, 1'b1, 1'b1);
    bus_read(1'b1, v);
`ifdef PS2_PARITY_CHK_EN
    n_cmp++;
    if (v !== 32'h10000) begin
      n_err++; $display("FAIL badpar_status: got %h want %h", v, 32'h10000);
    end
    bus_write(1'b1, 32'h8);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL perr_clear: got %h want %h", v, 32'h0); end
`else
    n_cmp++;
    if (v !== 32'h101) begin n_err++; $display("FAIL badpar_status: got %h want %h", v, 32'h101); end
    bus_read(1'b0, v);
    n_cmp++;
    if (v !== 32'hE) begin n_err++; $display("FAIL badpar_data: got %h want %h", v, 32'hE); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    send_frame(8'h16, 1'b0, 1'b1);
    send_frame(8'h1E, 1'b0, 1'b1);
    send_frame(8'h26, 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h301) begin n_err++; $display("FAIL rst_pre_status: got %h want %h", v, 32'h301); end
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #3 rst = 1'b0;
    sel = 1'b1; addr = 1'b1;
    #1 v = data_out;
    sel = 1'b0; addr = 1'b0;
    n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL rst_mid_status: got %h want %h", v, 32'h0); end
    n_cmp++;
    if (key_avail !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_avail: got %b want 0", key_avail);
    end
    PS2_CLK = 1'b1; PS2_DATA = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 send_frame(8'h66, 1'b0, 1'b1);
    bus_read(1'b1, v);
    n_cmp++;
    if (v !== 32'h101) begin n_err++; $display("FAIL rst_post_status: got %h want %h", v, 32'h101); end
    bus_read(1'b0, v);
    n_cmp++;
    if (v !== 32'hF) begin n_err++; $display("FAIL rst_post_data: got %h want %h", v, 32'hF); end
  endtask

  initial begin
    rst = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1;
    sel = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_basic;
    test_extended;
    test_keymap;
    test_overflow;
    test_timeout;
    test_bad_frames;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
